// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store unit between execute and a single-port word memory.
// Accepts one load or store per handshake. It drives the memory address, read
// and byte-strobe signals, and formats loaded bytes and halfwords with sign or
// zero extension. Misaligned, illegal-width and out-of-range requests are
// answered with rsp_err and never reach the memory.
//
// Ports:
//   clk, rstn                    clock (rising edge), async active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_funct3           store flag, RV32I width/signedness code
//   req_addr, req_wdata          byte address, right-aligned store data
//   rsp_valid/rsp_ready          response handshake (response held until taken)
//   rsp_data, rsp_err            load result (0 for stores/errors), reject flag
//   mem_addr, mem_read           word address and read enable to memory
//   mem_wstrb, mem_wdata         byte write strobes and replicated store data
//   mem_rdata                    memory read data, valid the cycle after mem_read
module riscv_lsu #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        f3_legal;
  logic        misalign;
  logic        out_of_range;
  logic        err;
  logic        acc;
  logic [3:0]  strb;
  logic [31:0] load_fmt;

  // Gating with rstn keeps the memory quiet while reset is held.
  assign req_ready = (state == IDLE) && rstn;

  always_comb begin
    f3_legal = 1'b0;
    misalign = 1'b0;
    case (req_funct3)
      3'b000: f3_legal = 1'b1;
      3'b001: begin
        f3_legal = 1'b1;
        misalign = req_addr[0];
      end
      3'b010: begin
        f3_legal = 1'b1;
        misalign = |req_addr[1:0];
      end
      3'b100: f3_legal = !req_we;
      3'b101: begin
        f3_legal = !req_we;
        misalign = req_addr[0];
      end
      default: f3_legal = 1'b0;
    endcase
  end

  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH);
  assign err          = !f3_legal || misalign || out_of_range;
  assign acc          = req_valid && req_ready && !err;

  assign mem_addr = {req_addr[31:2], 2'b00};
  assign mem_read = acc && !req_we;

  always_comb begin
    strb      = 4'b1111;
    mem_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        strb      = 4'b0001 << req_addr[1:0];
        mem_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb      = 4'b0011 << {req_addr[1], 1'b0};
        mem_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        mem_wdata = req_wdata;
      end
    endcase
  end

  assign mem_wstrb = (acc && req_we) ? strb : 4'b0000;

  // Format uses the offset and funct3 captured at accept, since req_* are
  // don't-care once the request has been taken.
  always_comb begin
    load_fmt = mem_rdata;
    case (f3_q)
      3'b000: load_fmt = {{24{mem_rdata[{off_q, 3'b111}]}}, mem_rdata[{off_q, 3'b000} +: 8]};
      3'b001: load_fmt = {{16{mem_rdata[{off_q[1], 4'b1111}]}}, mem_rdata[{off_q[1], 4'b0000} +: 16]};
      3'b100: load_fmt = {24'h000000, mem_rdata[{off_q, 3'b000} +: 8]};
      3'b101: load_fmt = {16'h0000, mem_rdata[{off_q[1], 4'b0000} +: 16]};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      off_q     <= '0;
      f3_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (err || req_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_data  <= '0;
            end else begin
              state <= LOAD_WAIT;
              off_q <= req_addr[1:0];
              f3_q  <= req_funct3;
            end
          end
        end
        LOAD_WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= load_fmt;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the core's execute stage and the single-port word memory `RiscvMem`. It accepts one RV32I load or store per handshake and generates the memory's `addr`/`read`/`wStrb`/`wData`. Loaded bytes and halfwords are extracted from the word and sign- or zero-extended. Misaligned, illegal-width and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- `MEM_DEPTH`, default 1024: memory depth in 32-bit words; must match the attached memory.

Ports:
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (width and signedness).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (low byte/halfword used).
- `rsp_valid` out 1: response present; held until `rsp_ready`.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_data` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: access rejected.
- `mem_addr` out 32: to memory `addr`; `{req_addr[31:2],2'b00}`.
- `mem_read` out 1: to memory `read`.
- `mem_wstrb` out 4: to memory `wStrb`; bit i enables byte i (bits 8i+7:8i).
- `mem_wdata` out 32: to memory `wData`.
- `mem_rdata` in 32: from memory `rData`; valid one cycle after `mem_read`.

## Operation
- FSM states: IDLE, LOAD_WAIT, RESP. `req_ready` = (state == IDLE) and rstn high.
- Memory outputs are combinational from the request, gated by `acc = req_valid && req_ready && !err`. When `acc` is 0: `mem_read`=0, `mem_wstrb`=0.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- `err` = illegal funct3, or halfword with `addr[0]`=1, or word with `addr[1:0]`≠0, or `addr[31:2] >= MEM_DEPTH`.
- Store strobes:
  - SB: `4'b0001 << addr[1:0]`, `mem_wdata = {4{wdata[7:0]}}`.
  - SH: `4'b0011 << {addr[1],1'b0}`, `mem_wdata = {2{wdata[15:0]}}`.
  - SW: `4'b1111`, `mem_wdata = wdata`.
- Loads: `mem_read`=1. On accept, register `addr[1:0]` and funct3.
- Transitions:
  - IDLE, accept load → LOAD_WAIT.
  - IDLE, accept store or errored request → RESP. A store writes memory on the accept edge.
  - LOAD_WAIT → RESP, registering the formatted data in `rsp_data` with `rsp_err`=0.
  - RESP, `rsp_ready`=1 → IDLE.
- Load format:
  - LB/LBU: select byte `mem_rdata[8*off+:8]`.
  - LH/LHU: select halfword `mem_rdata[16*off[1]+:16]`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Errored request: `rsp_err`=1, `rsp_data`=0, no memory strobe or read.
- Store response: `rsp_err`=0, `rsp_data`=0.
- `rsp_data` and `rsp_err` are stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset (async):
  - State = IDLE; `rsp_valid`, `rsp_err` = 0; `rsp_data` = 0.
  - `req_ready`, `mem_read`, `mem_wstrb` forced to 0 while `rstn`=0.
  - A load or store in flight at reset is dropped with no response. A store already clocked into memory stays written.
- Load accepted at cycle T:
  - Memory samples at edge ending T; `mem_rdata` valid in T+1.
  - `rsp_valid`=1 from T+2.
- Store or error accepted at T: `rsp_valid`=1 from T+1.
- Response handshake at cycle R: `rsp_valid`=0 and `req_ready`=1 at R+1.
- Peak throughput with `rsp_ready` tied high:
  - Loads: one per 3 cycles.
  - Stores: one per 2 cycles.
- `req_*` inputs are don't-care outside the accept cycle. Requests are not buffered; an unaccepted `req_valid` simply waits.

## Test plan
- SW addr 0x10, data 0xDEADBEEF; then LW 0x10:
  - Store: `mem_wstrb`=1111 on accept, `rsp_valid` at T+1, `rsp_err`=0.
  - Load: `rsp_data`=0xDEADBEEF at T+2.
- After the SW above, LB/LBU at 0x13, 0x12, 0x11, 0x10 → 0xFFFFFFDE/0x000000DE, 0xFFFFFFAD/0xAD, 0xFFFFFFBE/0xBE, 0xFFFFFFEF/0xEF.
- SH 0x22 data 0x00001234:
  - `mem_wstrb`=1100, `mem_wdata`=0x12341234.
  - LH 0x22 → 0x00001234; LHU 0x20 → upper bits 0, prior contents of 0x20–0x21 unchanged.
- Errors, each giving `rsp_err`=1, `rsp_data`=0, `mem_read`=0, `mem_wstrb`=0, `rsp_valid` at T+1:
  - LW 0x11; SH 0x01; LB with funct3 011; LW at 0x1000 with MEM_DEPTH=1024.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after a load response → `rsp_valid` and `rsp_data` stable, `req_ready`=0; release → IDLE the next cycle.
- Assert `rstn` low during LOAD_WAIT → `rsp_valid`=0, `req_ready`=1 after release, no response for the dropped load. The next LW returns correct data.
